// File: rtl/single_macc_coeff_loader.sv
// ---------------------------------------------------------------------------
// single_macc_coeff_loader
//   Takes a byte stream over a valid/ready handshake, packs every
//   BYTES_PER_COEFF bytes (MSB byte first) into one coefficient, and writes
//   the coefficients to the single-MACC FIR coefficient port at addresses
//   0..NUM_TAPS-1. While a load runs, DataHold_o tells the sample source to
//   keep DataNd_i low.
//
// Ports
//   Clk_i        rising-edge clock (filter clock; CoeffClk_i is tied to it)
//   Rst_i        synchronous active-high reset
//   Start_i      begin a load (honoured only when idle)
//   Abort_i      cancel a load in progress, no Done_o pulse
//   Byte_i       coefficient byte, MSB byte first
//   ByteValid_i  Byte_i valid
//   ByteReady_o  byte accepted this cycle when ByteValid_i is high
//   CoeffAddr_o  coefficient address to the filter
//   CoeffData_o  coefficient data to the filter
//   CoeffWr_o    one-cycle write strobe to the filter
//   Busy_o       receiving or writing a coefficient
//   DataHold_o   sample source must not assert DataNd_i
//   Done_o       one-cycle pulse after the last coefficient is written
// ---------------------------------------------------------------------------
module single_macc_coeff_loader #(
    parameter int NUM_TAPS        = 16,
    parameter int ADDR_W          = 4,
    parameter int COEFF_W         = 18,
    parameter int BYTES_PER_COEFF = 3
) (
    input  logic               Clk_i,
    input  logic               Rst_i,
    input  logic               Start_i,
    input  logic               Abort_i,
    input  logic [7:0]         Byte_i,
    input  logic               ByteValid_i,
    output logic               ByteReady_o,
    output logic [ADDR_W-1:0]  CoeffAddr_o,
    output logic [COEFF_W-1:0] CoeffData_o,
    output logic               CoeffWr_o,
    output logic               Busy_o,
    output logic               DataHold_o,
    output logic               Done_o
);

    localparam int CNT_W = $clog2(BYTES_PER_COEFF + 1);
    localparam int SH_W  = 8 * (BYTES_PER_COEFF - 1);
    localparam int WD_W  = 8 * BYTES_PER_COEFF;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES_PER_COEFF - 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [CNT_W-1:0]   r_bytecnt;
    logic [SH_W-1:0]    r_shift;      // earlier bytes of the current coefficient
    logic [ADDR_W-1:0]  r_coeff_addr;
    logic [COEFF_W-1:0] r_coeff_data;

    logic               w_xfer;
    logic               w_last_xfer;
    logic [WD_W-1:0]    w_word;

    assign w_xfer      = (r_state == S_RECV) && ByteValid_i;
    // Abort beats the final byte: no write is scheduled.
    assign w_last_xfer = w_xfer && (r_bytecnt == LAST_BYTE) && !Abort_i;
    // Full word with the incoming byte as LSB; the top bits of the first
    // byte beyond COEFF_W are dropped by the truncating cast below.
    assign w_word      = {r_shift, Byte_i};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (Start_i) w_next = S_RECV;
            S_RECV: begin
                if (Abort_i)          w_next = S_IDLE;
                else if (w_last_xfer) w_next = S_WRITE;
            end
            S_WRITE: begin
                if (Abort_i)                  w_next = S_IDLE;
                else if (r_addr == LAST_ADDR) w_next = S_DONE;
                else                          w_next = S_RECV;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_bytecnt    <= '0;
            r_shift      <= '0;
            r_coeff_addr <= '0;
            r_coeff_data <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (Start_i) begin
                        r_addr    <= '0;
                        r_bytecnt <= '0;
                    end
                end
                S_RECV: begin
                    if (w_xfer && !Abort_i) begin
                        r_shift   <= SH_W'(w_word);
                        r_bytecnt <= r_bytecnt + 1'b1;
                    end
                    // Capture address/data now so they are registered and
                    // stable during the WRITE cycle and held afterwards.
                    if (w_last_xfer) begin
                        r_coeff_addr <= r_addr;
                        r_coeff_data <= COEFF_W'(w_word);
                    end
                end
                S_WRITE: begin
                    if (!Abort_i && r_addr != LAST_ADDR) begin
                        r_addr    <= r_addr + 1'b1;
                        r_bytecnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ByteReady_o = (r_state == S_RECV);
    assign CoeffWr_o   = (r_state == S_WRITE);
    assign CoeffAddr_o = r_coeff_addr;
    assign CoeffData_o = r_coeff_data;
    assign Busy_o      = (r_state == S_RECV) || (r_state == S_WRITE);
    assign DataHold_o  = (r_state != S_IDLE);
    assign Done_o      = (r_state == S_DONE);

endmodule

// File: tb/tb_single_macc_coeff_loader.sv
// ---------------------------------------------------------------------------
// Testbench for single_macc_coeff_loader: table-driven packing vectors plus
// directed sequences for full load, backpressure, abort, start-while-busy
// and mid-load reset. Cycle 0 is the cycle in which Start_i is sampled.
// ---------------------------------------------------------------------------
module tb_single_macc_coeff_loader;

    logic        Clk = 1'b0;
    logic        Rst, Start, Abort, ByteValid;
    logic [7:0]  Byte;
    logic        ByteReady;
    logic [3:0]  CoeffAddr;
    logic [17:0] CoeffData;
    logic        CoeffWr, Busy, DataHold, Done;

    single_macc_coeff_loader dut (
        .Clk_i(Clk), .Rst_i(Rst), .Start_i(Start), .Abort_i(Abort),
        .Byte_i(Byte), .ByteValid_i(ByteValid), .ByteReady_o(ByteReady),
        .CoeffAddr_o(CoeffAddr), .CoeffData_o(CoeffData), .CoeffWr_o(CoeffWr),
        .Busy_o(Busy), .DataHold_o(DataHold), .Done_o(Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          c;
        logic [3:0]  a;
        logic [17:0] d;
    } wr_t;

    typedef struct {
        logic [7:0]  b0, b1, b2;
        logic [17:0] exp;
    } vec_t;

    int   n_pass = 0, n_chk = 0, cyc = 0;
    wr_t  wrq[$];
    int   doneq[$];
    logic hold_log[0:255];
    int   acc_cyc;
    int   la[16];
    vec_t tbl[6];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One clock cycle: sample outputs at negedge, then advance past posedge.
    task automatic tick(output bit acc);
        @(negedge Clk);
        acc = ByteValid && ByteReady && !Rst;
        if (CoeffWr) begin
            wrq.push_back('{cyc, CoeffAddr, CoeffData});
            check("ready_low_in_write", 32'(ByteReady), 0);
        end
        if (Done) doneq.push_back(cyc);
        if (cyc < 256) hold_log[cyc] = DataHold;
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        bit a;
        tick(a);
    endtask

    task automatic begin_load();
        wrq.delete();
        doneq.delete();
        for (int i = 0; i < 256; i++) hold_log[i] = 1'b0;
        cyc   = 0;
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic send(logic [7:0] b, bit bp);
        bit acc;
        if (bp) begin
            ByteValid = 1'b0;
            step();
        end
        ByteValid = 1'b1;
        Byte      = b;
        acc       = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) tick(acc);
        ByteValid = 1'b0;
        if (!acc) check("byte_accept_timeout", 0, 1);
        acc_cyc = cyc - 1;
    endtask

    task automatic send_coeff(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, bit bp);
        send(b0, bp);
        send(b1, bp);
        send(b2, bp);
    endtask

    task automatic run_until(int c);
        for (int i = 0; i < 200 && cyc < c; i++) step();
    endtask

    initial begin
        int hc, n;
        logic [7:0] kb;
        tbl[0] = '{8'hFF, 8'h12, 8'h34, 18'h31234};
        tbl[1] = '{8'h02, 8'h00, 8'h00, 18'h20000};
        tbl[2] = '{8'h01, 8'hFF, 8'hFF, 18'h1FFFF};
        tbl[3] = '{8'hAB, 8'hCD, 8'hEF, 18'h3CDEF};
        tbl[4] = '{8'hFC, 8'h00, 8'h01, 18'h00001};
        tbl[5] = '{8'h03, 8'hFF, 8'hFF, 18'h3FFFF};

        // ---- reset (Start held too: reset must win) ----
        Rst = 1'b1; Start = 1'b1; Abort = 1'b0; ByteValid = 1'b0; Byte = 8'h00;
        step(); step();
        Rst = 1'b0; Start = 1'b0;
        check("rst_ready", 32'(ByteReady), 0);
        check("rst_wr",    32'(CoeffWr), 0);
        check("rst_busy",  32'(Busy), 0);
        check("rst_hold",  32'(DataHold), 0);
        check("rst_done",  32'(Done), 0);
        check("rst_addr",  32'(CoeffAddr), 0);
        check("rst_data",  32'(CoeffData), 0);

        // ---- full load, back-to-back bytes ----
        begin_load();
        for (int k = 0; k < 16; k++) send_coeff(8'h00, 8'(k), 8'(k), 1'b0);
        run_until(70);
        check("full_nwrites", 32'(wrq.size()), 16);
        for (int k = 0; k < 16 && k < wrq.size(); k++) begin
            check("full_wcyc", 32'(wrq[k].c), 32'(4 * (k + 1)));
            check("full_addr", 32'(wrq[k].a), 32'(k));
            check("full_data", 32'(wrq[k].d), 32'(18'h00101 * k));
        end
        check("full_ndone", 32'(doneq.size()), 1);
        if (doneq.size() > 0) check("full_done_cyc", 32'(doneq[0]), 65);
        hc = 0;
        for (int i = 0; i < 70; i++) hc += int'(hold_log[i]);
        check("full_hold_count", 32'(hc), 65);
        check("full_hold_c0",  32'(hold_log[0]), 0);
        check("full_hold_c1",  32'(hold_log[1]), 1);
        check("full_hold_c65", 32'(hold_log[65]), 1);
        check("full_hold_c66", 32'(hold_log[66]), 0);

        // ---- packing table with 1-0-1 backpressure ----
        begin_load();
        for (int k = 0; k < 16; k++) begin
            if (k < 6) send_coeff(tbl[k].b0, tbl[k].b1, tbl[k].b2, 1'b1);
            else       send_coeff(8'h00, 8'h00, 8'(k), 1'b1);
            la[k] = acc_cyc;
        end
        run_until(cyc + 5);
        check("pack_nwrites", 32'(wrq.size()), 16);
        for (int k = 0; k < 16 && k < wrq.size(); k++) begin
            check("pack_data", 32'(wrq[k].d), (k < 6) ? 32'(tbl[k].exp) : 32'(k));
            check("pack_addr", 32'(wrq[k].a), 32'(k));
            check("pack_latency", 32'(wrq[k].c), 32'(la[k] + 1));
        end
        check("pack_ndone", 32'(doneq.size()), 1);

        // ---- abort in RECV after 5 coefficients + 1 byte ----
        begin_load();
        for (int k = 0; k < 5; k++) send_coeff(8'h00, 8'h11, 8'(k), 1'b0);
        send(8'h00, 1'b0);
        Abort = 1'b1; ByteValid = 1'b1; Byte = 8'h55;
        step();
        Abort = 1'b0; ByteValid = 1'b0;
        check("abort_hold_in_abort_cycle", 32'(hold_log[cyc - 1]), 1);
        check("abort_busy",  32'(Busy), 0);
        check("abort_ready", 32'(ByteReady), 0);
        check("abort_hold",  32'(DataHold), 0);
        run_until(cyc + 4);
        check("abort_nwrites", 32'(wrq.size()), 5);
        for (int k = 0; k < 5 && k < wrq.size(); k++)
            check("abort_addr", 32'(wrq[k].a), 32'(k));
        check("abort_ndone", 32'(doneq.size()), 0);

        // ---- restart after abort, then abort during the WRITE cycle ----
        begin_load();
        send_coeff(8'h01, 8'h23, 8'h45, 1'b0);
        check("restart_in_write", 32'(CoeffWr), 1);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        check("wabort_busy", 32'(Busy), 0);
        run_until(cyc + 4);
        check("restart_nwrites", 32'(wrq.size()), 1);
        if (wrq.size() > 0) begin
            check("restart_addr", 32'(wrq[0].a), 0);
            check("restart_data", 32'(wrq[0].d), 32'h12345);
        end
        check("wabort_ndone", 32'(doneq.size()), 0);

        // ---- Start pulsed while busy is ignored ----
        begin_load();
        for (int k = 0; k < 16; k++) begin
            if (k == 7) begin
                Start = 1'b1;
                step();
                Start = 1'b0;
            end
            kb = 8'(k);
            send_coeff(kb, 8'(k * 3), ~kb, 1'b0);
        end
        run_until(cyc + 5);
        check("busy_start_nwrites", 32'(wrq.size()), 16);
        for (int k = 0; k < 16 && k < wrq.size(); k++) begin
            kb = 8'(k);
            check("busy_start_addr", 32'(wrq[k].a), 32'(k));
            check("busy_start_data", 32'(wrq[k].d), 32'({kb[1:0], 8'(k * 3), ~kb}));
        end
        check("busy_start_ndone", 32'(doneq.size()), 1);

        // ---- reset mid-load ----
        begin_load();
        for (int k = 0; k < 10; k++) send_coeff(8'h00, 8'h00, 8'(k + 1), 1'b0);
        send(8'h00, 1'b0);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        check("mrst_ready", 32'(ByteReady), 0);
        check("mrst_wr",    32'(CoeffWr), 0);
        check("mrst_busy",  32'(Busy), 0);
        check("mrst_hold",  32'(DataHold), 0);
        check("mrst_done",  32'(Done), 0);
        check("mrst_addr",  32'(CoeffAddr), 0);
        check("mrst_data",  32'(CoeffData), 0);
        n = wrq.size();
        check("mrst_writes_before", 32'(n), 10);
        ByteValid = 1'b1; Byte = 8'h77;
        run_until(cyc + 10);
        ByteValid = 1'b0;
        check("mrst_no_more_writes", 32'(wrq.size()), 32'(n));
        check("mrst_ready_after", 32'(ByteReady), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/single_macc_coeff_loader.md
Name: single_macc_coeff_loader

Overview:
Coefficient-write initiator for the single-MACC FIR filter. It accepts a byte stream over a valid/ready handshake, packs each group of bytes into one coefficient, and drives the filter's coefficient write port (address, data, write strobe) for all taps in order. It runs on the filter clock, with the filter's CoeffClk_i tied to Clk_i. During a reload it asserts a hold flag so the sample source suppresses DataNd_i.

Parameters:
NUM_TAPS, 16, number of coefficients written per load; addresses 0..NUM_TAPS-1
ADDR_W, 4, coefficient address width; 2**ADDR_W >= NUM_TAPS
COEFF_W, 18, coefficient width
BYTES_PER_COEFF, 3, bytes per coefficient; equals ceil(COEFF_W/8)

Ports:
Clk_i  in  1  clock; all logic on the rising edge
Rst_i  in  1  synchronous reset, active-high
Start_i  in  1  begin a load; sampled only in IDLE
Abort_i  in  1  cancel the load in progress; return to IDLE with no Done_o pulse
Byte_i  in  8  coefficient byte, MSB byte first
ByteValid_i  in  1  Byte_i valid
ByteReady_o  out  1  loader accepts Byte_i this cycle
CoeffAddr_o  out  ADDR_W  connects to filter CoeffAddr_i
CoeffData_o  out  COEFF_W  connects to filter CoeffData_i
CoeffWr_o  out  1  one-cycle write strobe; connects to filter CoeffWr_i
Busy_o  out  1  load in progress (RECV or WRITE state)
DataHold_o  out  1  sample source must not assert DataNd_i while this is high
Done_o  out  1  one-cycle pulse after the last coefficient is written

Behaviour:
- Reset: state IDLE; every output is 0; address counter, byte counter and shift register are cleared. Reset wins over every other input in the same cycle. Reset in the middle of a load discards the partial load. Coefficients already written stay in the filter.
- States: IDLE, RECV, WRITE, DONE.
- IDLE: Start_i=1 moves to RECV next cycle and clears addr=0 and bytecnt=0. Abort_i has no effect in IDLE.
- RECV: ByteReady_o=1. A byte transfers when ByteValid_i && ByteReady_o.
  - Each transfer shifts the byte into the shift register and increments bytecnt.
  - The transfer of byte BYTES_PER_COEFF-1 moves to WRITE.
  - ByteValid_i low just stalls; there is no timeout.
- Packing (COEFF_W=18, BYTES_PER_COEFF=3): data = {b0[1:0], b1, b2}. Bits of b0 above COEFF_W-16 are ignored.
- WRITE: lasts exactly one cycle.
  - CoeffWr_o=1 with CoeffAddr_o=addr and CoeffData_o=the packed word, all registered outputs.
  - ByteReady_o=0.
  - If addr==NUM_TAPS-1, go to DONE. Otherwise addr++, bytecnt=0, and go to RECV.
- DONE: Done_o=1 for one cycle, then IDLE.
- Latency: the last byte of a coefficient is accepted in cycle N, and CoeffWr_o is high in cycle N+1. CoeffAddr_o and CoeffData_o hold their values outside write cycles; only CoeffWr_o qualifies them.
- Timing with back-to-back bytes: Start_i sampled at cycle 0, first byte accepted at cycle 1, writes at cycles 4, 8, ..., 64, Done_o at cycle 65.
- Busy_o = (state==RECV || state==WRITE).
- DataHold_o: high from the cycle after Start_i is accepted through the DONE cycle inclusive. It also stays high in the cycle an abort is taken.
- Start_i while not in IDLE is ignored; it does not restart the load.
- Abort_i in RECV or WRITE moves to IDLE next cycle, with no Done_o pulse.
  - Abort_i wins over a simultaneous byte transfer or write: the strobe in the WRITE cycle is still issued, but nothing follows it.
  - After an abort, ByteReady_o=0 and DataHold_o=0 from the next cycle.
- Address never wraps: the load always ends at NUM_TAPS-1.

Test Plan:
- Full load: Start_i at cycle 0, 48 back-to-back bytes encoding coeff k = 0x100*k + k -> 16 writes at cycles 4,8,...,64 with addr k and data 0x00101*k; Done_o high only at cycle 65; DataHold_o high cycles 1..65.
- Packing and sign bits: bytes 0xFF,0x12,0x34 -> CoeffData_o=0x31234; bytes 0x02,0x00,0x00 -> 0x20000.
- Backpressure: ByteValid_i toggled 1-0-1 on every byte -> identical write contents; each CoeffWr_o exactly one cycle after the coefficient's third accepted byte; ByteReady_o=0 in every WRITE cycle.
- Abort: Abort_i after 5 coefficients plus 1 byte -> exactly 5 writes (addr 0..4), no Done_o, state IDLE; a new Start_i then writes addr 0 first.
- Start while busy and reset mid-load: Start_i pulsed at coefficient 7 -> no effect, load completes normally; Rst_i at coefficient 10 -> all outputs 0 next cycle and no further CoeffWr_o.
- Integration with singleMaccFilter: load a single coefficient of 0x1FFFF at addr 0 with the rest 0, apply an impulse of 0x1FFFF -> the filter output shows one nonzero sample, and no DataNd_i occurs while DataHold_o=1.
